// File: rtl/key_debounce_if.sv
`default_nettype none
// key_debounce_if: raw key pins in, debounced keys and event pulses out.
interface key_debounce_if #(
  parameter int N = 13
);
  logic [N-1:0] key_raw;
  logic [N-1:0] keys;
  logic [N-1:0] key_edge;
  logic         any_press;

  modport master (output key_raw, input keys, key_edge, any_press);
  modport slave  (input key_raw, output keys, key_edge, any_press);
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_debounce: sync + tick-based debounce of N key lines, edge/press pulses|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module key_debounce #(
  parameter int N        = 13,
  parameter int PRESCALE = 50000,
  parameter int STABLE   = 5,
  parameter bit INVERT   = 1'b1
) (
  input  logic           clk,
  input  logic           nreset,
  key_debounce_if.slave  bus
);
  localparam int c_pre_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_cnt_w = ($clog2(STABLE + 1) > 1) ? $clog2(STABLE + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE - 1);

  logic [N-1:0]       w_p;
  logic [N-1:0]       r_s0;
  logic [N-1:0]       r_s1;
  logic [N-1:0]       r_keys;
  logic [N-1:0]       r_edge;
  logic [N-1:0]       w_commit;
  logic               r_any;
  logic               w_tick;
  logic [c_cnt_w-1:0] r_cnt [N];

  assign w_p = bus.key_raw ^ {N{INVERT}};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_s0 <= '0;
      r_s1 <= '0;
    end else begin
      r_s0 <= w_p;
      r_s1 <= r_s0;
    end
  end

  generate
    if (PRESCALE > 1) begin : g_presc
      localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);
      logic [c_pre_w-1:0] r_pre;

      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset)
          r_pre <= '0;
        else if (r_pre == c_pre_last)
          r_pre <= '0;
        else
          r_pre <= r_pre + c_pre_w'(1);
      end

      assign w_tick = (r_pre == c_pre_last);
    end else begin : g_presc_bypass
      assign w_tick = 1'b1;
    end
  endgenerate

  always_comb begin
    w_commit = '0;
    for (int i = 0; i < N; i++)
      w_commit[i] = (r_s1[i] != r_keys[i]) && w_tick && (r_cnt[i] == c_cnt_last);
  end

  // A bounce back to the accepted level clears the count, so only an
  // uninterrupted run of STABLE ticks can commit a new level.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_keys <= '0;
      r_edge <= '0;
      r_any  <= 1'b0;
      for (int i = 0; i < N; i++)
        r_cnt[i] <= '0;
    end else begin
      r_edge <= w_commit;
      r_any  <= |(w_commit & r_s1);
      for (int i = 0; i < N; i++) begin
        if (r_s1[i] == r_keys[i]) begin
          r_cnt[i] <= '0;
        end else if (w_commit[i]) begin
          r_keys[i] <= r_s1[i];
          r_cnt[i]  <= '0;
        end else if (w_tick) begin
          r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
        end
      end
    end
  end

  assign bus.keys      = r_keys;
  assign bus.key_edge  = r_edge;
  assign bus.any_press = r_any;
endmodule
`default_nettype wire
